spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parametrised successor to the team's fixed 8+16-bit SPI register controller.
- Runs one SPI frame per start request: address phase followed by a data phase, in write or read mode.
- Adds a configurable SCLK divider, programmable chip-select setup/hold, a start/busy/done handshake, read-data capture with a valid strobe, and a timed device-reset pulse after system reset.
- Sits between the configuration sequencer and an external SPI-programmable converter.

Parameters:
- ADDR_W, 8, address bits per frame (>=1).
- DATA_W, 16, data bits per frame (>=1).
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1).
- CS_SETUP, 2, clk cycles sen is low before the first SCLK low phase (>=1).
- CS_HOLD, 2, clk cycles sen stays low after the last SCLK high phase (>=1).
- RST_PULSE, 4, clk cycles dev_resetn is held low after resetn is released (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- wr_mode  in  1  1 = write frame, 0 = read frame; latched on acceptance.
- addr  in  ADDR_W  register address; latched on acceptance.
- wdata  in  DATA_W  write data; latched on acceptance.
- busy  out  1  high whenever the block is not in IDLE.
- done  out  1  one-cycle pulse at frame end.
- rd_data  out  DATA_W  last captured read data.
- rd_valid  out  1  one-cycle pulse with done on read frames only.
- sen  out  1  active-low chip select.
- sclk  out  1  SPI clock, mode 0 (idles low).
- sdin  out  1  serial data to the device.
- sdout  in  1  serial data from the device.
- dev_resetn  out  1  active-low device reset.

Behaviour:
- Reset values (asynchronous, immediate): sen=1, sclk=0, sdin=0, done=0, rd_valid=0, rd_data=0, dev_resetn=0, busy=1, state=RST_WAIT.
- States: RST_WAIT -> IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- RST_WAIT: counts RST_PULSE cycles after resetn deasserts, then sets dev_resetn=1 and enters IDLE with busy=0 in the same cycle.
- IDLE: if start=1 at the clock edge, latch wr_mode/addr/wdata into the shift register.
  - The frame shifted is {addr, wdata} on writes and {addr, DATA_W'b0} on reads, MSB first; N = ADDR_W + DATA_W.
  - Next cycle: sen=0, busy=1, sdin=frame MSB, state SETUP.
  - If start=0, hold all outputs.
- SETUP: CS_SETUP cycles with sen low and sclk low, then SHIFT.
- SHIFT: each bit is a CLK_DIV-cycle low phase followed by a CLK_DIV-cycle high phase.
  - sdin updates only at the start of a low phase: bit 0 is presented on SETUP entry, bit k>0 on the falling-edge cycle.
  - Bit counter runs 0..N-1. After the high phase of bit N-1, sclk returns low and the state moves to HOLD.
- Read capture: on the clk edge where sclk goes 0->1 for bits ADDR_W..N-1, shift sdout into the capture register, MSB first.
  - Address-phase bits are not captured. sdin=0 throughout the data phase.
- HOLD: CS_HOLD cycles with sen low and sclk low, then DONE.
- DONE: one cycle with sen=1, done=1, busy=1.
  - On read frames: rd_valid=1 and rd_data loads the capture register. rd_data holds until the next read DONE; write frames never change it.
- Timing:
  - busy-high span from the cycle after acceptance: CS_SETUP + 2*CLK_DIV*N + CS_HOLD + 1. With defaults this is 101 cycles.
  - Minimum sen-high gap between back-to-back frames is 2 cycles (DONE cycle + acceptance cycle).
- start while busy=1 is ignored, not queued. wr_mode/addr/wdata changes mid-frame have no effect.
- resetn asserted mid-frame aborts immediately to reset values. No done or rd_valid is emitted, and dev_resetn pulses again.
- Counters must be sized to hold their maximum values: N, CLK_DIV, CS_SETUP, CS_HOLD and RST_PULSE.

Test Plan:
- Reset release with defaults -> dev_resetn low for exactly 4 cycles after resetn rises; busy falls in the same cycle dev_resetn rises; sen=1, sclk=0 throughout.
- Write addr=8'hA5, wdata=16'h3C0F, defaults -> sdin stream 1010_0101_0011_1100_0000_1111 sampled on 24 sclk rising edges; sclk period 4 clk; done one cycle, 101 cycles after acceptance; rd_valid stays 0.
- Read addr=8'h12, device model drives 16'hBEEF on sdout during the data phase -> sdin carries 0001_0010 then zeros; rd_data=16'hBEEF with rd_valid=1 coincident with done.
- start pulsed mid-frame, and start held high continuously -> mid-frame start is ignored; held start launches frames with exactly 2 sen-high cycles between them.
- resetn asserted during bit 10 of a write -> sen=1, sclk=0, busy=1, dev_resetn=0 in the same cycle; no done; normal write after recovery.
- Rebuild with ADDR_W=7, DATA_W=9, CLK_DIV=1, CS_SETUP=1, CS_HOLD=3 -> 16 sclk pulses of period 2 clk; busy span 1+32+3+1=37 cycles.

Source files
------------

// File: rtl/spi_master_param.sv
// ============================================================================
// Module   : spi_master_param
// Brief    : Parametrised SPI register master (address + data frame, mode 0)
//            with SCLK divider, CS setup/hold, read capture and device reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_param #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 2,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int RST_PULSE = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              wr_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              sen,
  output logic              sclk,
  output logic              sdin,
  input  logic              sdout,
  output logic              dev_resetn
);

  localparam int N        = ADDR_W + DATA_W;
  localparam int CNT_MAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX  = (CNT_MAX0 > RST_PULSE) ? CNT_MAX0 : RST_PULSE;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int DIV_W    = $clog2(CLK_DIV + 1);
  localparam int BIT_W    = $clog2(N + 1);

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    IDLE     = 3'd1,
    SETUP    = 3'd2,
    SHIFT    = 3'd3,
    HOLD     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              phase_q, phase_d;
  logic              wr_q, wr_d;
  logic [N-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic              sen_q, sen_d;
  logic              sclk_q, sclk_d;
  logic              sdin_q, sdin_d;
  logic              dev_resetn_q, dev_resetn_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    wr_d         = wr_q;
    shreg_d      = shreg_q;
    cap_d        = cap_q;
    rd_data_d    = rd_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_valid_d   = 1'b0;
    sen_d        = sen_q;
    sclk_d       = sclk_q;
    sdin_d       = sdin_q;
    dev_resetn_d = dev_resetn_q;

    case (state_q)
      RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_PULSE - 1)) begin
          dev_resetn_d = 1'b1;
          busy_d       = 1'b0;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      IDLE: begin
        if (start) begin
          wr_d    = wr_mode;
          shreg_d = wr_mode ? {addr, wdata} : {addr, {DATA_W{1'b0}}};
          sdin_d  = addr[ADDR_W-1];
          cap_d   = '0;
          sen_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!phase_q) begin
            // Rising SCLK edge: device output is sampled in the same clk edge
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            if (!wr_q && (bit_q >= BIT_W'(ADDR_W)))
              cap_d = DATA_W'({cap_q, sdout});
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == BIT_W'(N - 1)) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shreg_d = shreg_q << 1;
              sdin_d  = shreg_q[N-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          sen_d   = 1'b1;
          sdin_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
          if (!wr_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = cap_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RST_WAIT;
      cnt_q        <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      wr_q         <= 1'b0;
      shreg_q      <= '0;
      cap_q        <= '0;
      rd_data_q    <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      sen_q        <= 1'b1;
      sclk_q       <= 1'b0;
      sdin_q       <= 1'b0;
      dev_resetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      wr_q         <= wr_d;
      shreg_q      <= shreg_d;
      cap_q        <= cap_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
      sen_q        <= sen_d;
      sclk_q       <= sclk_d;
      sdin_q       <= sdin_d;
      dev_resetn_q <= dev_resetn_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign sen        = sen_q;
  assign sclk       = sclk_q;
  assign sdin       = sdin_q;
  assign dev_resetn = dev_resetn_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_param.sv
// ============================================================================
// Module   : tb_spi_master_param
// Brief    : Directed self-checking bench for spi_master_param (default build
//            plus a reduced 7+9-bit, CLK_DIV=1 build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_a, start_b;
  logic        wr_mode;
  logic [7:0]  addr;
  logic [15:0] wdata;

  logic        busy_a, done_a, rd_valid_a, sen_a, sclk_a, sdin_a, sdout_a, dev_resetn_a;
  logic [15:0] rd_data_a;
  logic        busy_b, done_b, rd_valid_b, sen_b, sclk_b, sdin_b, sdout_b, dev_resetn_b;
  logic [8:0]  rd_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_param u_dut_a (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start_a),
    .wr_mode    (wr_mode),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy_a),
    .done       (done_a),
    .rd_data    (rd_data_a),
    .rd_valid   (rd_valid_a),
    .sen        (sen_a),
    .sclk       (sclk_a),
    .sdin       (sdin_a),
    .sdout      (sdout_a),
    .dev_resetn (dev_resetn_a)
  );

  spi_master_param #(
    .ADDR_W   (7),
    .DATA_W   (9),
    .CLK_DIV  (1),
    .CS_SETUP (1),
    .CS_HOLD  (3)
  ) u_dut_b (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start_b),
    .wr_mode    (wr_mode),
    .addr       (addr[6:0]),
    .wdata      (wdata[8:0]),
    .busy       (busy_b),
    .done       (done_b),
    .rd_data    (rd_data_b),
    .rd_valid   (rd_valid_b),
    .sen        (sen_b),
    .sclk       (sclk_b),
    .sdin       (sdin_b),
    .sdout      (sdout_b),
    .dev_resetn (dev_resetn_b)
  );

  // Device model for the default build: drives dev_data during the data phase
  logic [15:0] dev_data;
  int          idx_a;
  always @(posedge sclk_a or posedge sen_a) begin
    if (sen_a) idx_a <= 0;
    else       idx_a <= idx_a + 1;
  end
  always_comb begin
    sdout_a = 1'b0;
    if (idx_a >= 8 && idx_a < 24) sdout_a = dev_data[23 - idx_a];
  end
  assign sdout_b = 1'b0;

  logic sel;
  logic m_busy, m_done, m_rv, m_sclk, m_sdin;
  always_comb begin
    m_busy = sel ? busy_b     : busy_a;
    m_done = sel ? done_b     : done_a;
    m_rv   = sel ? rd_valid_b : rd_valid_a;
    m_sclk = sel ? sclk_b     : sclk_a;
    m_sdin = sel ? sdin_b     : sdin_a;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  logic [31:0] r_stream;
  int r_nrise, r_period, r_span, r_done_at, r_done_cnt, r_rv_cnt, r_rv_at;
  bit r_timeout;

  // Launches one frame on the selected DUT and records what appears on its pins
  task automatic run_frame(input logic wr, input logic [7:0] a, input logic [15:0] d,
                           input int poke_at);
    int c, last;
    logic prev;
    r_stream = '0; r_nrise = 0; r_period = 0; r_span = 0;
    r_done_at = -1; r_done_cnt = 0; r_rv_cnt = 0; r_rv_at = -1; r_timeout = 1'b1;
    @(negedge clk);
    wr_mode = wr; addr = a; wdata = d;
    set_start(1'b1);
    @(posedge clk); #1;
    c = 0; last = 0; prev = 1'b0;
    while (c < 400) begin
      set_start(c == poke_at);
      if (m_busy) r_span++;
      if (m_done) begin r_done_cnt++; r_done_at = c; end
      if (m_rv)   begin r_rv_cnt++;   r_rv_at   = c; end
      if (m_sclk && !prev) begin
        r_stream = {r_stream[30:0], m_sdin};
        r_nrise++;
        if (r_nrise >= 2) begin
          if (r_period == 0)              r_period = c - last;
          else if (r_period != c - last)  r_period = -1;
        end
        last = c;
      end
      prev = m_sclk;
      if (!m_busy && c > 0) begin r_timeout = 1'b0; break; end
      @(posedge clk); #1;
      c++;
    end
    set_start(1'b0);
    check_eq("frame_timeout", {31'd0, r_timeout}, 32'd0);
  endtask

  // After resetn rises at a negedge, counts edges until dev_resetn is released
  task automatic check_dev_reset(input string tag);
    int cyc;
    bit quiet, busy_ok;
    cyc = 0; quiet = 1'b1; busy_ok = 1'b1;
    while (cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (sen_a !== 1'b1 || sclk_a !== 1'b0 || sen_b !== 1'b1 || sclk_b !== 1'b0) quiet = 1'b0;
      if (dev_resetn_a === 1'b1) break;
      if (busy_a !== 1'b1) busy_ok = 1'b0;
    end
    check_eq({tag, "_pulse_len"}, cyc, 32'd4);
    check_eq({tag, "_busy_fall"}, {31'd0, busy_a}, 32'd0);
    check_eq({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, "_quiet"}, {31'd0, quiet}, 32'd1);
    check_eq({tag, "_b_ready"}, {30'd0, dev_resetn_b, busy_b}, 32'd2);
  endtask

  initial begin
    int c, rises, dn, gap, ndone;
    logic prev;
    bit counted;
    sel = 1'b0; start_a = 1'b0; start_b = 1'b0;
    wr_mode = 1'b0; addr = '0; wdata = '0; dev_data = 16'hBEEF;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs",
             {24'd0, sen_a, sclk_a, sdin_a, done_a, rd_valid_a, dev_resetn_a, busy_a, 1'b0},
             {24'd0, 8'b1000_0010});
    check_eq("rst_rd_data", {16'd0, rd_data_a}, 32'd0);
    @(negedge clk) resetn = 1'b1;
    check_dev_reset("por");

    // Write A5/3C0F
    run_frame(1'b1, 8'hA5, 16'h3C0F, -1);
    check_eq("wr_stream", r_stream, 32'h00A53C0F);
    check_eq("wr_nrise", r_nrise, 32'd24);
    check_eq("wr_period", r_period, 32'd4);
    check_eq("wr_span", r_span, 32'd101);
    check_eq("wr_done_at", r_done_at, 32'd100);
    check_eq("wr_done_cnt", r_done_cnt, 32'd1);
    check_eq("wr_rv_cnt", r_rv_cnt, 32'd0);
    check_eq("wr_rd_data", {16'd0, rd_data_a}, 32'd0);

    // Read 12 with device returning BEEF
    run_frame(1'b0, 8'h12, 16'hFFFF, -1);
    check_eq("rd_stream", r_stream, 32'h00120000);
    check_eq("rd_span", r_span, 32'd101);
    check_eq("rd_rv_cnt", r_rv_cnt, 32'd1);
    check_eq("rd_rv_with_done", r_rv_at, r_done_at);
    check_eq("rd_done_at", r_done_at, 32'd100);
    check_eq("rd_data", {16'd0, rd_data_a}, 32'h0000BEEF);

    // Write with a stray start pulse mid-frame
    run_frame(1'b1, 8'h0F, 16'hA5A5, 30);
    check_eq("poke_stream", r_stream, 32'h000FA5A5);
    check_eq("poke_span", r_span, 32'd101);
    check_eq("poke_done_cnt", r_done_cnt, 32'd1);
    dn = 0;
    repeat (5) begin @(posedge clk); #1; if (busy_a) dn++; end
    check_eq("poke_no_queue", dn, 32'd0);
    check_eq("poke_rd_data_kept", {16'd0, rd_data_a}, 32'h0000BEEF);

    // Start held high: back-to-back frames
    @(negedge clk);
    wr_mode = 1'b1; addr = 8'h33; wdata = 16'h0001; start_a = 1'b1;
    c = 0; ndone = 0; gap = 0; counted = 1'b0;
    while (c < 600 && ndone < 2) begin
      @(posedge clk); #1;
      c++;
      if (done_a) ndone++;
      if (ndone == 1 && !counted) begin
        if (sen_a) gap++;
        else       counted = 1'b1;
      end
    end
    start_a = 1'b0;
    check_eq("held_done_cnt", ndone, 32'd2);
    check_eq("held_sen_gap", gap, 32'd2);
    @(posedge clk); #1;
    check_eq("held_idle", {30'd0, busy_a, sen_a}, 32'd1);

    // Reset asserted during bit 10 of a write
    @(negedge clk);
    wr_mode = 1'b1; addr = 8'hC7; wdata = 16'h1234; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    c = 0; rises = 0; dn = 0; prev = 1'b0;
    while (c < 400 && rises < 11) begin
      @(posedge clk); #1;
      c++;
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
      if (done_a) dn++;
    end
    check_eq("abort_reached_bit10", rises, 32'd11);
    #2 resetn = 1'b0;
    #1;
    check_eq("abort_outputs", {28'd0, sen_a, sclk_a, busy_a, dev_resetn_a}, 32'b1010);
    repeat (3) begin @(posedge clk); #1; if (done_a || rd_valid_a) dn++; end
    check_eq("abort_no_done", dn, 32'd0);
    @(negedge clk) resetn = 1'b1;
    check_dev_reset("abort");
    run_frame(1'b1, 8'h5A, 16'hC3F0, -1);
    check_eq("recover_stream", r_stream, 32'h005AC3F0);
    check_eq("recover_span", r_span, 32'd101);

    // Reduced build: 7+9 bits, CLK_DIV=1, CS_SETUP=1, CS_HOLD=3
    sel = 1'b1;
    run_frame(1'b1, 8'h55, 16'h01A3, -1);
    check_eq("b_stream", r_stream, 32'h0000ABA3);
    check_eq("b_nrise", r_nrise, 32'd16);
    check_eq("b_period", r_period, 32'd2);
    check_eq("b_span", r_span, 32'd37);
    check_eq("b_done_at", r_done_at, 32'd36);
    check_eq("b_rv_cnt", r_rv_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
